// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencing controller:
// cell select codes, command op codes and controller states.
package usr_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/usr_shift_cnt.sv
// Loadable down-counter for shift lengths; load values above WIDTH saturate
// to WIDTH, and counting stops at zero.
module usr_shift_cnt
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] load_sat;

  assign load_sat = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_sat;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/usr_seq_ctrl.sv
// Word-level command sequencer for a universal shift register: drives the
// shared cell select and end-cell fills, and streams out the departing bit.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             ser_in,
  input  logic             stall,
  input  logic             abort,
  input  logic             reg_msb,
  input  logic             reg_lsb,
  output logic [1:0]       sel,
  output logic             msb_fill,
  output logic             lsb_fill,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             aborted
);

  state_e state_q, state_d;
  logic   shl_q, shl_d;
  logic   aborted_q;
  logic   cnt_load, cnt_en, cnt_zero, cnt_last;
  op_e    op;

  assign op = op_e'(cmd_op);

  usr_shift_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cmd_len),
    .en       (cnt_en),
    .count    (remaining),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shl_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shl_q     <= shl_d;
      // Only meaningful during the DONE cycle that follows an abort.
      aborted_q <= (state_q == ST_SHIFT) && abort;
    end
  end

  // Next state, counter control and per-cycle cell drive.
  always_comb begin
    state_d       = state_q;
    shl_d         = shl_q;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    sel           = SEL_HOLD;
    msb_fill      = 1'b0;
    lsb_fill      = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_LOAD: state_d = ST_LOAD;
            OP_SHR, OP_SHL: begin
              shl_d    = (op == OP_SHL);
              cnt_load = 1'b1;
              state_d  = (cmd_len == '0) ? ST_DONE : ST_SHIFT;
            end
            default: state_d = ST_DONE;
          endcase
        end
      end

      ST_LOAD: begin
        sel     = SEL_LOAD;
        state_d = ST_DONE;
      end

      ST_SHIFT: begin
        // Abort wins over stall and suppresses the shift in its own cycle.
        if (abort) begin
          state_d = ST_DONE;
        end else if (!stall) begin
          cnt_en        = 1'b1;
          ser_out_valid = 1'b1;
          if (shl_q) begin
            sel      = SEL_SHL;
            ser_out  = reg_msb;
            lsb_fill = ser_in;
          end else begin
            sel      = SEL_SHR;
            ser_out  = reg_lsb;
            msb_fill = ser_in;
          end
          if (cnt_last || cnt_zero) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl: an 8-cell register plus a transaction-level model
// that expands each command into the expected per-cycle output sequence.
module tb_usr_seq_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [1:0]    sel;
    logic          mf;
    logic          lf;
    logic          sv;
    logic          so;
    logic          busy;
    logic          done;
    logic          ab;
    logic          rdy;
    logic [CW-1:0] rem;
    logic [W-1:0]  q;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] cmd_len = '0;
  logic          ser_in = 1'b0;
  logic          stall = 1'b0;
  logic          abort = 1'b0;
  logic          reg_msb, reg_lsb;
  logic [1:0]    sel;
  logic          msb_fill, lsb_fill, ser_out, ser_out_valid, busy, done, aborted;
  logic [CW-1:0] remaining;
  logic [W-1:0]  d_in = '0;
  logic [W-1:0]  q = '0;

  int n_vec = 0;
  int n_err = 0;

  exp_t          mq[$];
  logic [W-1:0]  m_reg = '0;
  int            m_rem = 0;
  bit            chk_en = 1'b0;

  logic [15:0]   cap;
  int            n_valid, n_busy;
  logic [CW-1:0] d_rem;
  logic          d_ab;
  exp_t          ce;

  usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .ser_in(ser_in), .stall(stall),
    .abort(abort), .reg_msb(reg_msb), .reg_lsb(reg_lsb), .sel(sel),
    .msb_fill(msb_fill), .lsb_fill(lsb_fill), .ser_out(ser_out),
    .ser_out_valid(ser_out_valid), .busy(busy), .remaining(remaining),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // The register cells driven by the controller.
  always @(posedge clk) begin
    case (sel)
      2'b01:   q <= {msb_fill, q[W-1:1]};
      2'b10:   q <= {q[W-2:0], lsb_fill};
      2'b11:   q <= d_in;
      default: q <= q;
    endcase
  end
  assign reg_msb = q[W-1];
  assign reg_lsb = q[0];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic exp_t base_e(bit is_busy);
    exp_t e;
    e      = '0;
    e.busy = is_busy;
    e.rdy  = !is_busy;
    e.rem  = CW'(m_rem);
    e.q    = m_reg;
    return e;
  endfunction

  // Expand one command into its expected cycle-by-cycle outputs, starting
  // with the accept cycle.
  task automatic gen_cmd(input logic [1:0] op, input int len, input logic sin,
                         input logic [W-1:0] d, input logic [15:0] smask,
                         input int abort_at);
    exp_t e;
    bit   shl, ab;
    mq.push_back(base_e(1'b0));
    ab = 1'b0;
    if (op == 2'b11) begin
      e = base_e(1'b1); e.sel = 2'b11; mq.push_back(e);
      m_reg = d;
    end else if (op != 2'b00) begin
      shl   = (op == 2'b10);
      m_rem = (len > int'(W)) ? int'(W) : len;
      for (int j = 0; j < 40 && m_rem > 0; j++) begin
        e = base_e(1'b1);
        if (j == abort_at) begin
          mq.push_back(e);
          ab = 1'b1;
          break;
        end
        if (!(j < 16 && smask[j])) begin
          e.sel = shl ? 2'b10 : 2'b01;
          e.sv  = 1'b1;
          e.so  = shl ? m_reg[W-1] : m_reg[0];
          if (shl) e.lf = sin; else e.mf = sin;
          m_reg = shl ? {m_reg[W-2:0], sin} : {sin, m_reg[W-1:1]};
          m_rem--;
        end
        mq.push_back(e);
      end
    end
    e = base_e(1'b1); e.done = 1'b1; e.ab = ab;
    mq.push_back(e);
  endtask

  // Single compare process: every cycle against the model queue (idle when empty).
  always @(negedge clk) begin
    if (chk_en) begin
      if (mq.size() > 0) ce = mq.pop_front();
      else               ce = base_e(1'b0);
      chk("sel", sel, ce.sel);
      chk("msb_fill", msb_fill, ce.mf);
      chk("lsb_fill", lsb_fill, ce.lf);
      chk("ser_out_valid", ser_out_valid, ce.sv);
      if (ce.sv) chk("ser_out", ser_out, ce.so);
      chk("busy", busy, ce.busy);
      chk("done", done, ce.done);
      chk("aborted", aborted, ce.ab);
      chk("cmd_ready", cmd_ready, ce.rdy);
      chk("remaining", remaining, ce.rem);
      chk("reg", q, ce.q);
      if (ser_out_valid) begin
        cap = {cap[14:0], ser_out};
        n_valid++;
      end
      if (busy && !done) n_busy++;
      if (done) begin
        d_rem = remaining;
        d_ab  = aborted;
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input int len, input logic sin,
                         input logic [W-1:0] d, input logic [15:0] smask,
                         input int abort_at, input bit noise);
    int start, n;
    cap = '0; n_valid = 0; n_busy = 0; d_rem = 4'hF; d_ab = 1'bx;
    cmd_op = op; cmd_len = CW'(len); ser_in = sin; d_in = d;
    cmd_valid = 1'b1; stall = 1'b0; abort = 1'b0;
    start = mq.size();
    gen_cmd(op, len, sin, d, smask, abort_at);
    n = mq.size() - start;
    @(posedge clk); #1;
    cmd_valid = noise;
    if (noise) begin cmd_op = 2'b11; cmd_len = '0; end
    for (int i = 1; i < n; i++) begin
      stall = (i - 1 < 16) ? smask[i-1] : 1'b0;
      abort = ((i - 1) == abort_at);
      if (i == n - 1) cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    stall = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst sel", sel, 2'b00);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst aborted", aborted, 1'b0);
    chk("rst remaining", remaining, 4'd0);
    chk("rst ser_out_valid", ser_out_valid, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("ready after reset", cmd_ready, 1'b1);

    // LOAD A5, with a stray stall/abort during the LOAD cycle
    run_cmd(2'b11, 0, 1'b0, 8'hA5, 16'hFFFF, 0, 1'b0);
    chk("load value", q, 8'hA5);
    chk("load busy cycles", n_busy, 1);

    // SHR 8, zero fill: the whole word streams out LSB first
    run_cmd(2'b01, 8, 1'b0, 8'h00, 16'h0000, -1, 1'b0);
    chk("shr8 stream", cap[7:0], 8'hA5);
    chk("shr8 valid count", n_valid, 8);
    chk("shr8 final", q, 8'h00);
    chk("shr8 not aborted", d_ab, 1'b0);

    // SHL 3 on 81 with one-fill
    run_cmd(2'b11, 0, 1'b0, 8'h81, 16'h0000, -1, 1'b0);
    run_cmd(2'b10, 3, 1'b1, 8'h00, 16'h0000, -1, 1'b0);
    chk("shl3 stream", cap[2:0], 3'b100);
    chk("shl3 final", q, 8'h0F);
    chk("shl3 done remaining", d_rem, 4'd0);

    // SHR 4 stalled two cycles after the first shift, commands offered while busy
    run_cmd(2'b11, 0, 1'b0, 8'hF0, 16'h0000, -1, 1'b0);
    run_cmd(2'b01, 4, 1'b1, 8'h00, 16'h0006, -1, 1'b1);
    chk("stall final", q, 8'hFF);
    chk("stall shift-phase cycles", n_busy, 6);
    chk("stall valid count", n_valid, 4);

    // SHR 8 aborted on the third shift cycle
    run_cmd(2'b11, 0, 1'b0, 8'hA5, 16'h0000, -1, 1'b0);
    run_cmd(2'b01, 8, 1'b0, 8'h00, 16'h0000, 2, 1'b0);
    chk("abort final", q, 8'h29);
    chk("abort remaining", d_rem, 4'd6);
    chk("abort flag", d_ab, 1'b1);
    chk("abort valid count", n_valid, 2);

    // Zero-length shift and NOP complete immediately
    run_cmd(2'b10, 0, 1'b1, 8'h00, 16'h0000, -1, 1'b0);
    chk("len0 busy cycles", n_busy, 0);
    chk("len0 remaining", d_rem, 4'd0);
    run_cmd(2'b00, 5, 1'b1, 8'h00, 16'h0000, -1, 1'b0);
    chk("nop valid count", n_valid, 0);

    // Over-length request saturates to WIDTH shifts
    run_cmd(2'b11, 0, 1'b0, 8'h3C, 16'h0000, -1, 1'b0);
    run_cmd(2'b10, 15, 1'b0, 8'h00, 16'h0000, -1, 1'b0);
    chk("len15 valid count", n_valid, 8);
    chk("len15 final", q, 8'h00);

    // Asynchronous reset in the middle of a shift
    chk_en = 1'b0;
    cmd_op = 2'b01; cmd_len = 4'd8; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre-reset sel", sel, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("async rst sel", sel, 2'b00);
    chk("async rst busy", busy, 1'b0);
    chk("async rst remaining", remaining, 4'd0);
    chk("async rst valid", ser_out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset ready", cmd_ready, 1'b1);
    chk("post-reset busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
